adder_bist_checker: RTL and testbench
=====================================

ADDER_BIST_CHECKER -- requirements
Module: adder_bist_checker

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 1, number of cycles the vector is held before the adder outputs are sampled (legal range 1..15).
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a full 16-vector test run.
REQ-005 Ports a1, a0, b1, b0, output, 1 bit each: operand bits driven to the 2-bit adder under test.
REQ-006 Ports c, s1, s0, input, 1 bit each: carry and sum bits returned by the adder under test.
REQ-007 Port busy, output, 1 bit: a run is in progress.
REQ-008 Port done, output, 1 bit: the run is complete and the result is valid.
REQ-009 Port pass, output, 1 bit: high when done is high and zero mismatches were recorded.
REQ-010 Port err_count, output, 5 bits: number of mismatching vectors (0..16).
REQ-011 Port fail_valid, output, 1 bit: at least one mismatch recorded this run.
REQ-012 Port first_fail, output, 4 bits: index of the first mismatching vector.

Function
REQ-013 The block SHALL hold a 4-bit vector index v and drive a1=v[3], a0=v[2], b1=v[1], b0=v[0] directly from registers.
REQ-014 Expected response SHALL be {c,s1,s0} = {a1,a0} + {b1,b0}, a 3-bit unsigned sum with no truncation.
REQ-015 The FSM SHALL have four states: IDLE, SETTLE, CHECK, DONE.
REQ-016 IDLE or DONE with start=1 SHALL, in one edge:
- set v=0 and the settle counter=0;
- clear err_count, fail_valid and first_fail;
- enter SETTLE.
REQ-017 SETTLE SHALL increment the settle counter each cycle and enter CHECK on the edge where the counter equals SETTLE-1.
REQ-018 CHECK SHALL last exactly one cycle and compare {c,s1,s0} with the expected value for the current v.
REQ-019 On a CHECK mismatch, err_count SHALL increment by 1; if fail_valid=0, first_fail SHALL take v and fail_valid SHALL set to 1.
REQ-020 From CHECK with v=15 the FSM SHALL enter DONE; otherwise v SHALL increment by 1, the settle counter SHALL clear, and the FSM SHALL enter SETTLE.
REQ-021 Each vector SHALL take exactly SETTLE+1 cycles, so DONE is entered 16*(SETTLE+1) edges after the start edge.
REQ-022 busy SHALL be 1 exactly in SETTLE and CHECK; done SHALL be 1 exactly in DONE; pass SHALL be done AND (err_count==0).
REQ-023 start SHALL be ignored while busy=1.
REQ-024 DONE SHALL hold v=15 and all result outputs until a start is accepted.
REQ-025 A start in DONE SHALL restart a full run with cleared results.
REQ-026 The c/s1/s0 inputs SHALL be sampled only in CHECK; their values in other states SHALL have no effect.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, v=0 (a1=a0=b1=b0=0), settle counter=0;
- busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0.
REQ-028 A reset during a run SHALL abort the run with no partial result kept. After reset release, the block SHALL stay in IDLE until start.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Correct adder model, SETTLE=1, one-cycle start pulse -> busy for 32 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
- Adder model with c stuck at 0 -> done with err_count=6, fail_valid=1, first_fail=7, pass=0.
- Adder model with s0 inverted -> err_count=16, first_fail=0, pass=0.
- SETTLE=3, correct model -> done exactly 64 edges after start; each vector held 4 cycles, sampled only in its last cycle.
- start pulsed mid-run -> no effect on v or timing. start pulsed in DONE -> err_count cleared and v=0 on the next edge, then a full new run.
- rst asserted at v=9 -> all outputs at reset values immediately; no done until a new start, and the new run completes normally.

Source files
------------

// File: rtl/adder_bist_checker.sv
// Built-in self-test controller for a 2-bit adder. It walks all 16 operand pairs, holds each
// one for SETTLE cycles, samples the adder response in a single CHECK cycle, and records
// the error count and the first failing vector.
module adder_bist_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a1,
  output logic       a0,
  output logic       b1,
  output logic       b0,
  input  logic       c,
  input  logic       s1,
  input  logic       s0,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] first_fail
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  // Counter value seen on the last settle cycle of a vector.
  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e     state_q;
  logic [3:0] v_q;
  logic [3:0] cnt_q;
  logic [4:0] err_q;
  logic       fv_q;
  logic [3:0] ff_q;
  logic       busy_q;
  logic       done_q;

  logic [2:0] exp_sum;
  logic       mismatch;

  // Golden response for the vector currently driven; widened so the carry is kept.
  always_comb begin
    exp_sum  = {1'b0, v_q[3:2]} + {1'b0, v_q[1:0]};
    mismatch = ({c, s1, s0} != exp_sum);
  end

  // Sequencer: vector walk, settle timing, result capture and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      v_q     <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 5'd0;
      fv_q    <= 1'b0;
      ff_q    <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StSettle;
            v_q     <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 5'd0;
            fv_q    <= 1'b0;
            ff_q    <= 4'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StSettle: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == SettleLast) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          // Adder inputs only matter here; every other state ignores c/s1/s0.
          if (mismatch) begin
            err_q <= err_q + 5'd1;
            if (!fv_q) begin
              fv_q <= 1'b1;
              ff_q <= v_q;
            end
          end
          if (v_q == 4'd15) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= StSettle;
            v_q     <= v_q + 4'd1;
            cnt_q   <= 4'd0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a1         = v_q[3];
  assign a0         = v_q[2];
  assign b1         = v_q[1];
  assign b0         = v_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q & (err_q == 5'd0);
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: two instances (SETTLE=1 and SETTLE=3) each driving a
// behavioural adder with selectable faults; run results are checked through scoreboards.
module tb_adder_bist_checker;

  typedef struct {
    int err;
    int fv;
    int ff;
    int pass;
    int edges;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- instance with SETTLE=1 ----------------
  logic       start1 = 1'b0;
  logic       d1_a1, d1_a0, d1_b1, d1_b0, d1_c, d1_s1, d1_s0;
  logic       busy1, done1, pass1, fv1;
  logic [4:0] err1;
  logic [3:0] ff1;
  logic [3:0] v1;
  int         mode1 = 0;
  int         start_cyc1 = 0;
  logic [2:0] sum1;

  assign v1 = {d1_a1, d1_a0, d1_b1, d1_b0};

  // Adder under test: 0 correct, 1 carry stuck at 0, 2 s0 inverted.
  always_comb begin
    sum1 = {1'b0, d1_a1, d1_a0} + {1'b0, d1_b1, d1_b0};
    case (mode1)
      1:       sum1[2] = 1'b0;
      2:       sum1[0] = ~sum1[0];
      default: ;
    endcase
  end
  assign {d1_c, d1_s1, d1_s0} = sum1;

  adder_bist_checker #(.SETTLE(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .a1        (d1_a1),
    .a0        (d1_a0),
    .b1        (d1_b1),
    .b0        (d1_b0),
    .c         (d1_c),
    .s1        (d1_s1),
    .s0        (d1_s0),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_count (err1),
    .fail_valid(fv1),
    .first_fail(ff1)
  );

  // ---------------- instance with SETTLE=3 ----------------
  logic       start3 = 1'b0;
  logic       d3_a1, d3_a0, d3_b1, d3_b0, d3_c, d3_s1, d3_s0;
  logic       busy3, done3, pass3, fv3;
  logic [4:0] err3;
  logic [3:0] ff3;
  int         mode3 = 0;
  int         start_cyc3 = 0;
  logic [2:0] sum3;

  // Mode 3 returns the right answer only in the 4th cycle of each vector, garbage otherwise.
  always_comb begin
    sum3 = {1'b0, d3_a1, d3_a0} + {1'b0, d3_b1, d3_b0};
    if (mode3 == 3 && ((cyc - start_cyc3) % 4) != 3) sum3 = ~sum3;
  end
  assign {d3_c, d3_s1, d3_s0} = sum3;

  adder_bist_checker #(.SETTLE(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .start     (start3),
    .a1        (d3_a1),
    .a0        (d3_a0),
    .b1        (d3_b1),
    .b0        (d3_b0),
    .c         (d3_c),
    .s1        (d3_s1),
    .s0        (d3_s0),
    .busy      (busy3),
    .done      (done3),
    .pass      (pass3),
    .err_count (err3),
    .fail_valid(fv3),
    .first_fail(ff3)
  );

  // ---------------- scoreboards / monitors ----------------
  exp_t q1[$];
  exp_t q3[$];

  logic done_prev1 = 1'b0, busy_prev1 = 1'b0;
  logic done_prev3 = 1'b0, busy_prev3 = 1'b0;
  int   bcnt1 = 0, bcnt3 = 0;

  // Monitor for the SETTLE=1 instance: compares each completed run against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (busy1) bcnt1 = busy_prev1 ? bcnt1 + 1 : 1;
    if (done1 && !done_prev1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d1_unexpected_done: got done=1 expected no run pending");
      end else begin
        e = q1.pop_front();
        check("d1_err_count", int'(err1), e.err);
        check("d1_fail_valid", int'(fv1), e.fv);
        check("d1_first_fail", int'(ff1), e.ff);
        check("d1_pass", int'(pass1), e.pass);
        check("d1_done_latency", cyc - start_cyc1, e.edges);
        check("d1_busy_cycles", bcnt1, e.edges);
      end
    end
    done_prev1 = done1;
    busy_prev1 = busy1;
  end

  // Monitor for the SETTLE=3 instance.
  always @(negedge clk) begin
    exp_t e;
    if (busy3) bcnt3 = busy_prev3 ? bcnt3 + 1 : 1;
    if (done3 && !done_prev3) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d3_unexpected_done: got done=1 expected no run pending");
      end else begin
        e = q3.pop_front();
        check("d3_err_count", int'(err3), e.err);
        check("d3_fail_valid", int'(fv3), e.fv);
        check("d3_first_fail", int'(ff3), e.ff);
        check("d3_pass", int'(pass3), e.pass);
        check("d3_done_latency", cyc - start_cyc3, e.edges);
        check("d3_busy_cycles", bcnt3, e.edges);
      end
    end
    done_prev3 = done3;
    busy_prev3 = busy3;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push1(input int err, input int fv, input int ff, input int ps);
    exp_t e;
    e.err = err; e.fv = fv; e.ff = ff; e.pass = ps; e.edges = 32;
    q1.push_back(e);
  endtask

  task automatic pulse_start1(input bit record);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    if (record) start_cyc1 = cyc;
    start1 = 1'b0;
  endtask

  task automatic wait_done1(input string name);
    int n = 0;
    while (!done1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done1) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done within 200 cycles expected done=1", name);
    end
    @(negedge clk);
  endtask

  task automatic wait_done3(input string name);
    int n = 0;
    while (!done3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done3) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done within 300 cycles expected done=1", name);
    end
    @(negedge clk);
  endtask

  task automatic run3(input int md);
    exp_t e;
    mode3 = md;
    e.err = 0; e.fv = 0; e.ff = 0; e.pass = 1; e.edges = 64;
    q3.push_back(e);
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start_cyc3 = cyc;
    start3 = 1'b0;
    wait_done3("d3_run_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy1), 0);
    check({tag, "_done"}, int'(done1), 0);
    check({tag, "_pass"}, int'(pass1), 0);
    check({tag, "_err_count"}, int'(err1), 0);
    check({tag, "_fail_valid"}, int'(fv1), 0);
    check({tag, "_first_fail"}, int'(ff1), 0);
    check({tag, "_vector"}, int'(v1), 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Correct adder: pass, and DONE holds v=15 with results stable.
    mode1 = 0;
    push1(0, 0, 0, 1);
    pulse_start1(1'b1);
    wait_done1("d1_good_timeout");
    repeat (3) @(negedge clk);
    check("done_hold_vector", int'(v1), 15);
    check("done_hold_done", int'(done1), 1);
    check("done_hold_pass", int'(pass1), 1);

    // Carry stuck at 0: six failures, first at a=1,b=3.
    mode1 = 1;
    push1(6, 1, 7, 0);
    pulse_start1(1'b1);
    wait_done1("d1_cstuck_timeout");

    // Restart from DONE with a good adder: results clear on the accepting edge.
    mode1 = 0;
    push1(0, 0, 0, 1);
    pulse_start1(1'b1);
    check("restart_err_cleared", int'(err1), 0);
    check("restart_fv_cleared", int'(fv1), 0);
    check("restart_vector_zero", int'(v1), 0);
    check("restart_busy", int'(busy1), 1);
    check("restart_done_low", int'(done1), 0);
    wait_done1("d1_restart_timeout");

    // s0 inverted: every vector fails.
    mode1 = 2;
    push1(16, 1, 0, 0);
    pulse_start1(1'b1);
    wait_done1("d1_s0inv_timeout");

    // start pulses while busy must not disturb timing or results.
    mode1 = 0;
    push1(0, 0, 0, 1);
    pulse_start1(1'b1);
    repeat (6) @(negedge clk);
    pulse_start1(1'b0);
    repeat (9) @(negedge clk);
    pulse_start1(1'b0);
    wait_done1("d1_midstart_timeout");

    // Reset at v=9 aborts the run immediately; block idles until a new start.
    mode1 = 1;
    pulse_start1(1'b1);
    n = 0;
    while (v1 != 4'd9 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("reached_vector_9", int'(v1), 9);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_idle_busy", int'(busy1), 0);
    check("post_rst_idle_done", int'(done1), 0);
    check("post_rst_idle_vector", int'(v1), 0);
    mode1 = 0;
    push1(0, 0, 0, 1);
    pulse_start1(1'b1);
    wait_done1("d1_after_rst_timeout");

    // SETTLE=3: correct model, then a model that is only right in the sampling cycle.
    run3(0);
    run3(3);

    check("q1_drained", q1.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule
